// File: rtl/dtc_cmd_master.sv
// ---------------------------------------------------------------------------
// dtc_cmd_master
//   Initiator-side command issuer for the DTC link. Accepts one host command
//   at a time, drives the DTC command strobe bundle toward the FEE decoder
//   and, for reads, waits for the reply frame and returns its data to the
//   host. Writes complete after a fixed idle gap because the FEE never
//   replies to them.
//
// Parameters
//   EXEC_CYCLES     width of the dtc_cmd_exec pulse (1..15)
//   WR_GAP_CYCLES   idle cycles after exec before a write completes (1..255)
//   TIMEOUT_CYCLES  max wait for a read reply after exec ends (1..4095)
//
// Optional feature
//   DTC_CMD_MASTER_ADDRCHK_EN  when defined, the reply address word is
//   compared against the issued command; a mismatch sets err[1] and
//   returns data 0.
//
// Ports
//   rdoclk, reset_n                       clock, async active-low reset
//   host_req_valid/ready/rnw/feenal/addr/wdata   host command channel
//   dtc_cmd_exec/rnw/feenal/addr/data     DTC command strobe bundle
//   reply_rdy/addr/data                   DTC reply frame
//   host_rsp_valid/ready/data/err         host response channel
//                                         (err[0] timeout, err[1] addr)
// ---------------------------------------------------------------------------
module dtc_cmd_master #(
    parameter int EXEC_CYCLES    = 4,
    parameter int WR_GAP_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        rdoclk,
    input  logic        reset_n,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic        host_req_rnw,
    input  logic        host_req_feenal,
    input  logic [19:0] host_req_addr,
    input  logic [19:0] host_req_wdata,
    output logic        dtc_cmd_exec,
    output logic        dtc_cmd_rnw,
    output logic        dtc_cmd_feenal,
    output logic [19:0] dtc_cmd_addr,
    output logic [19:0] dtc_cmd_data,
    input  logic        reply_rdy,
    input  logic [31:0] reply_addr,
    input  logic [31:0] reply_data,
    output logic        host_rsp_valid,
    input  logic        host_rsp_ready,
    output logic [19:0] host_rsp_data,
    output logic [1:0]  host_rsp_err
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WGAP,
        WRPLY,
        RESP
    } state_t;

    localparam logic [11:0] EXEC_LAST    = 12'(EXEC_CYCLES - 1);
    localparam logic [11:0] GAP_LAST     = 12'(WR_GAP_CYCLES - 1);
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [11:0] r_cnt;
    logic        r_reply_rdy_q;

    logic        w_reply_edge;
    logic [19:0] w_reply_rdata;
    logic        w_addr_err;

    // A reply level that is already high when WRPLY is entered must not be
    // taken as a new frame, so only a 0->1 transition counts.
    assign w_reply_edge  = reply_rdy & ~r_reply_rdy_q;

    // FPGA register reads carry 16 significant bits; ALTRO reads carry 20.
    assign w_reply_rdata = dtc_cmd_feenal ? reply_data[19:0]
                                          : {4'h0, reply_data[15:0]};

`ifdef DTC_CMD_MASTER_ADDRCHK_EN
    assign w_addr_err = (reply_addr != {1'b1, dtc_cmd_feenal, 10'h000, dtc_cmd_addr});
    logic w_unused;
    assign w_unused = ^reply_data[31:20];
`else
    assign w_addr_err = 1'b0;
    logic w_unused;
    assign w_unused = ^{reply_data[31:20], reply_addr};
`endif

    // NOTE: every register here is updated with non-blocking assignments so
    // all next-state values are computed from the same pre-edge snapshot.
    always_ff @(posedge rdoclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_reply_rdy_q  <= 1'b0;
            host_req_ready <= 1'b0;
            dtc_cmd_exec   <= 1'b0;
            dtc_cmd_rnw    <= 1'b0;
            dtc_cmd_feenal <= 1'b0;
            dtc_cmd_addr   <= '0;
            dtc_cmd_data   <= '0;
            host_rsp_valid <= 1'b0;
            host_rsp_data  <= '0;
            host_rsp_err   <= '0;
        end else begin
            r_reply_rdy_q <= reply_rdy;

            case (r_state)
                IDLE: begin
                    host_req_ready <= 1'b1;
                    if (host_req_valid && host_req_ready) begin
                        dtc_cmd_rnw    <= host_req_rnw;
                        dtc_cmd_feenal <= host_req_feenal;
                        dtc_cmd_addr   <= host_req_addr;
                        dtc_cmd_data   <= host_req_wdata;
                        dtc_cmd_exec   <= 1'b1;
                        host_req_ready <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= EXEC;
                    end
                end

                EXEC: begin
                    if (r_cnt == EXEC_LAST) begin
                        dtc_cmd_exec <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= dtc_cmd_rnw ? WRPLY : WGAP;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end

                WGAP: begin
                    if (r_cnt == GAP_LAST) begin
                        host_rsp_valid <= 1'b1;
                        host_rsp_data  <= '0;
                        host_rsp_err   <= 2'b00;
                        r_state        <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end

                WRPLY: begin
                    // A reply edge takes priority over the terminal count.
                    if (w_reply_edge) begin
                        host_rsp_valid <= 1'b1;
                        host_rsp_data  <= w_addr_err ? 20'h0 : w_reply_rdata;
                        host_rsp_err   <= {w_addr_err, 1'b0};
                        r_state        <= RESP;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        host_rsp_valid <= 1'b1;
                        host_rsp_data  <= '0;
                        host_rsp_err   <= 2'b01;
                        r_state        <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end

                RESP: begin
                    if (host_rsp_ready) begin
                        host_rsp_valid <= 1'b0;
                        host_req_ready <= 1'b1;
                        r_state        <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_dtc_cmd_master
//   Self-checking bench for dtc_cmd_master with default parameters
//   (EXEC 4, WR_GAP 8, TIMEOUT 1023). A table of directed commands is run
//   through a common task, followed by hand-written sequences for timeout
//   with a stale reply level, reset during exec, and a stalled response.
// ---------------------------------------------------------------------------
module tb_dtc_cmd_master;

    logic        rdoclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_req_valid = 1'b0;
    logic        host_req_ready;
    logic        host_req_rnw = 1'b0;
    logic        host_req_feenal = 1'b0;
    logic [19:0] host_req_addr = '0;
    logic [19:0] host_req_wdata = '0;
    logic        dtc_cmd_exec;
    logic        dtc_cmd_rnw;
    logic        dtc_cmd_feenal;
    logic [19:0] dtc_cmd_addr;
    logic [19:0] dtc_cmd_data;
    logic        reply_rdy = 1'b0;
    logic [31:0] reply_addr = '0;
    logic [31:0] reply_data = '0;
    logic        host_rsp_valid;
    logic        host_rsp_ready = 1'b0;
    logic [19:0] host_rsp_data;
    logic [1:0]  host_rsp_err;

    dtc_cmd_master dut (
        .rdoclk          (rdoclk),
        .reset_n         (reset_n),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_rnw    (host_req_rnw),
        .host_req_feenal (host_req_feenal),
        .host_req_addr   (host_req_addr),
        .host_req_wdata  (host_req_wdata),
        .dtc_cmd_exec    (dtc_cmd_exec),
        .dtc_cmd_rnw     (dtc_cmd_rnw),
        .dtc_cmd_feenal  (dtc_cmd_feenal),
        .dtc_cmd_addr    (dtc_cmd_addr),
        .dtc_cmd_data    (dtc_cmd_data),
        .reply_rdy       (reply_rdy),
        .reply_addr      (reply_addr),
        .reply_data      (reply_data),
        .host_rsp_valid  (host_rsp_valid),
        .host_rsp_ready  (host_rsp_ready),
        .host_rsp_data   (host_rsp_data),
        .host_rsp_err    (host_rsp_err)
    );

    always #5 rdoclk = ~rdoclk;

    typedef struct {
        logic        rnw;
        logic        feenal;
        logic [19:0] addr;
        logic [19:0] wdata;
        int          dly;        // cycles into WRPLY before the reply edge
        logic [31:0] rep_addr;
        logic [31:0] rep_data;
        logic [19:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[6];
    int   n_checks = 0;
    int   n_errors = 0;
    int   t = 0;                 // cycle index relative to acceptance cycle 0

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge rdoclk);
        #1;
        t++;
    endtask

    task automatic send(input logic rnw, input logic feenal,
                        input logic [19:0] addr, input logic [19:0] wdata);
        int n = 0;
        while (!host_req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(host_req_ready), 32'd1);
        host_req_valid  = 1'b1;
        host_req_rnw    = rnw;
        host_req_feenal = feenal;
        host_req_addr   = addr;
        host_req_wdata  = wdata;
        t = 0;
        tick();
        host_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max);
        int n = 0;
        while (!host_rsp_valid && n < max) begin
            tick();
            n++;
        end
        check("rsp_valid_wait", 32'(host_rsp_valid), 32'd1);
    endtask

    task automatic consume();
        host_rsp_ready = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
        check("rsp_valid_after_consume", 32'(host_rsp_valid), 32'd0);
        check("req_ready_after_consume", 32'(host_req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n = 0;
        send(v.rnw, v.feenal, v.addr, v.wdata);
        check($sformatf("v%0d_exec_start", idx), 32'(dtc_cmd_exec), 32'd1);
        check($sformatf("v%0d_ready_low", idx), 32'(host_req_ready), 32'd0);
        check($sformatf("v%0d_cmd_rnw", idx), 32'(dtc_cmd_rnw), 32'(v.rnw));
        check($sformatf("v%0d_cmd_feenal", idx), 32'(dtc_cmd_feenal), 32'(v.feenal));
        check($sformatf("v%0d_cmd_addr", idx), 32'(dtc_cmd_addr), 32'(v.addr));
        check($sformatf("v%0d_cmd_data", idx), 32'(dtc_cmd_data), 32'(v.wdata));
        while (dtc_cmd_exec && n < 20) begin
            n++;
            tick();
        end
        check($sformatf("v%0d_exec_width", idx), 32'(n), 32'd4);
        if (v.rnw) begin
            repeat (v.dly) tick();
            check($sformatf("v%0d_no_early_rsp", idx), 32'(host_rsp_valid), 32'd0);
            reply_addr = v.rep_addr;
            reply_data = v.rep_data;
            reply_rdy  = 1'b1;
            tick();
            check($sformatf("v%0d_read_latency", idx), 32'(host_rsp_valid), 32'd1);
            reply_rdy = 1'b0;
        end else begin
            wait_rsp(50);
            check($sformatf("v%0d_write_latency", idx), 32'(t), 32'd13);
        end
        check($sformatf("v%0d_rsp_data", idx), 32'(host_rsp_data), 32'(v.exp_data));
        check($sformatf("v%0d_rsp_err", idx), 32'(host_rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d_ready_vs_valid", idx), 32'(host_req_ready), 32'd0);
        consume();
    endtask

    initial begin
        logic [19:0] held;

        vecs[0] = '{1'b0, 1'b0, 20'h00012, 20'h0ABCD, 0, 32'h0, 32'h0, 20'h00000, 2'b00};
        vecs[1] = '{1'b1, 1'b1, 20'h4A003, 20'h0, 2, 32'hC004A003, 32'h000F1234, 20'hF1234, 2'b00};
`ifdef DTC_CMD_MASTER_ADDRCHK_EN
        vecs[2] = '{1'b1, 1'b0, 20'h00005, 20'h0, 1, 32'h80000006, 32'h000A5A5A, 20'h00000, 2'b10};
        vecs[4] = '{1'b1, 1'b1, 20'h00001, 20'h0, 3, 32'h40000001, 32'h00012345, 20'h00000, 2'b10};
`else
        vecs[2] = '{1'b1, 1'b0, 20'h00005, 20'h0, 1, 32'h80000006, 32'h000A5A5A, 20'h05A5A, 2'b00};
        vecs[4] = '{1'b1, 1'b1, 20'h00001, 20'h0, 3, 32'h40000001, 32'h00012345, 20'h12345, 2'b00};
`endif
        vecs[3] = '{1'b1, 1'b0, 20'h00777, 20'h0, 0, 32'h80000777, 32'hFFFFFFFF, 20'h0FFFF, 2'b00};
        vecs[5] = '{1'b0, 1'b1, 20'hFFFFF, 20'hFFFFF, 0, 32'h0, 32'h0, 20'h00000, 2'b00};

        // Reset state.
        #12;
        check("rst_req_ready", 32'(host_req_ready), 32'd0);
        check("rst_exec", 32'(dtc_cmd_exec), 32'd0);
        check("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
        check("rst_cmd_addr", 32'(dtc_cmd_addr), 32'd0);
        @(negedge rdoclk);
        reset_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(host_req_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Stale reply level present on WRPLY entry: must time out.
        reply_addr = 32'h80000010;
        reply_data = 32'h00001111;
        reply_rdy  = 1'b1;
        send(1'b1, 1'b0, 20'h00010, 20'h0);
        wait_rsp(1100);
        check("timeout_latency", 32'(t), 32'd1028);
        check("timeout_data", 32'(host_rsp_data), 32'd0);
        check("timeout_err", 32'(host_rsp_err), 32'd1);
        consume();
        reply_rdy = 1'b0;
        tick();

        // Reset asserted during exec cycle 2.
        send(1'b0, 1'b1, 20'h12345, 20'h54321);
        tick();
        check("exec_before_reset", 32'(dtc_cmd_exec), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("exec_async_drop", 32'(dtc_cmd_exec), 32'd0);
        check("cmd_addr_async_clr", 32'(dtc_cmd_addr), 32'd0);
        check("ready_in_reset", 32'(host_req_ready), 32'd0);
        repeat (2) @(posedge rdoclk);
        @(negedge rdoclk);
        reset_n = 1'b1;
        tick();
        check("ready_after_release", 32'(host_req_ready), 32'd1);
        run_vec(vecs[0], 6);

        // Stalled response: valid/data held, RESP-time reply edge ignored,
        // queued request accepted in the cycle after consumption.
        send(1'b1, 1'b1, 20'h4A003, 20'h0);
        repeat (6) tick();
        reply_addr = 32'hC004A003;
        reply_data = 32'h000ABCDE;
        reply_rdy  = 1'b1;
        tick();
        reply_rdy = 1'b0;
        check("stall_rsp_valid", 32'(host_rsp_valid), 32'd1);
        held = host_rsp_data;
        check("stall_first_data", 32'(held), 32'h0ABCDE);
        for (int i = 0; i < 20; i++) begin
            if (i == 8) begin
                reply_data = 32'h00011111;
                reply_rdy  = 1'b1;
            end
            if (i == 10) reply_rdy = 1'b0;
            tick();
            if (host_rsp_valid !== 1'b1 || host_rsp_data !== held || host_req_ready !== 1'b0) begin
                check("stall_hold", {host_req_ready, host_rsp_valid, 10'h0, host_rsp_data},
                      {1'b0, 1'b1, 10'h0, held});
            end
        end
        check("stall_data_end", 32'(host_rsp_data), 32'h0ABCDE);
        host_req_valid  = 1'b1;
        host_req_rnw    = 1'b0;
        host_req_feenal = 1'b0;
        host_req_addr   = 20'h00AAA;
        host_req_wdata  = 20'h00BBB;
        host_rsp_ready  = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
        check("b2b_valid_low", 32'(host_rsp_valid), 32'd0);
        check("b2b_ready_high", 32'(host_req_ready), 32'd1);
        check("b2b_not_yet_exec", 32'(dtc_cmd_exec), 32'd0);
        t = 0;
        tick();
        host_req_valid = 1'b0;
        check("b2b_accepted", 32'(dtc_cmd_exec), 32'd1);
        check("b2b_addr", 32'(dtc_cmd_addr), 32'h00AAA);
        wait_rsp(50);
        check("b2b_write_latency", 32'(t), 32'd13);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
